// File: rtl/uart_tx_stream.sv
// UART transmitter: 8 data bits LSB first, optional even parity, one stop bit,
// fed from a small byte FIFO through a valid/ready push port.
module uart_tx_stream #(
    parameter int CLK_FREQ_HZ = 50000000,
    parameter int BAUD_RATE   = 1562500,
    parameter int PARITY_EN   = 0,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [7:0]                       data_i,
    input  logic                             valid_i,
    output logic                             ready_o,
    output logic                             tx_o,
    output logic                             busy_o,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]  fifo_level_o
);

    localparam int DIV   = CLK_FREQ_HZ / BAUD_RATE;
    localparam int LVL_W = $clog2(FIFO_DEPTH + 1);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [LVL_W-1:0] FULL_LEVEL = LVL_W'(FIFO_DEPTH);
    localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(DIV - 1);

    generate
        if ((CLK_FREQ_HZ % BAUD_RATE) != 0 || DIV < 2 || FIFO_DEPTH < 2 ||
            (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_param_check
            $error("uart_tx_stream: need integer clock/baud ratio >= 2 and power-of-two FIFO_DEPTH >= 2");
        end
    endgenerate

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    logic [7:0]       mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [LVL_W-1:0] level;
    state_t           state;
    logic [CNT_W-1:0] baud_cnt;
    logic [2:0]       bit_idx;
    logic [2:0]       next_idx;
    logic [7:0]       frame_byte;
    logic             push;
    logic             pop;
    logic             baud_done;
    logic             fifo_empty;

    assign fifo_empty   = (level == '0);
    assign ready_o      = (level != FULL_LEVEL);
    assign push         = valid_i & ready_o;
    assign baud_done    = (baud_cnt == CNT_LAST);
    assign pop          = !fifo_empty && ((state == IDLE) || (state == STOP && baud_done));
    assign next_idx     = bit_idx + 3'd1;
    assign fifo_level_o = level;
    assign busy_o       = (state != IDLE) || !fifo_empty;

    // Storage needs no reset; the pointers and level define what is valid.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= data_i;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            if (push && !pop) begin
                level <= level + LVL_W'(1);
            end else if (pop && !push) begin
                level <= level - LVL_W'(1);
            end
        end
    end

    // The byte stays unshifted so the parity bit can be taken from it directly.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            baud_cnt   <= '0;
            bit_idx    <= '0;
            frame_byte <= '0;
            tx_o       <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    baud_cnt <= '0;
                    if (pop) begin
                        frame_byte <= mem[rd_ptr];
                        tx_o       <= 1'b0;
                        state      <= START;
                    end
                end
                START: begin
                    if (baud_done) begin
                        baud_cnt <= '0;
                        bit_idx  <= '0;
                        tx_o     <= frame_byte[0];
                        state    <= DATA;
                    end else begin
                        baud_cnt <= baud_cnt + CNT_W'(1);
                    end
                end
                DATA: begin
                    if (baud_done) begin
                        baud_cnt <= '0;
                        if (bit_idx != 3'd7) begin
                            bit_idx <= next_idx;
                            tx_o    <= frame_byte[next_idx];
                        end else if (PARITY_EN != 0) begin
                            tx_o  <= ^frame_byte;
                            state <= PARITY;
                        end else begin
                            tx_o  <= 1'b1;
                            state <= STOP;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + CNT_W'(1);
                    end
                end
                PARITY: begin
                    if (baud_done) begin
                        baud_cnt <= '0;
                        tx_o     <= 1'b1;
                        state    <= STOP;
                    end else begin
                        baud_cnt <= baud_cnt + CNT_W'(1);
                    end
                end
                STOP: begin
                    if (baud_done) begin
                        baud_cnt <= '0;
                        // A waiting byte starts immediately so frames run back to back.
                        if (pop) begin
                            frame_byte <= mem[rd_ptr];
                            tx_o       <= 1'b0;
                            state      <= START;
                        end else begin
                            state <= IDLE;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    baud_cnt <= '0;
                    tx_o     <= 1'b1;
                    state    <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_stream.sv
// Bench for uart_tx_stream: one instance without parity, one with even parity,
// each watched by a line-decoding monitor that checks frames against a byte scoreboard.
module tb_uart_tx_stream;

    localparam int DIV = 32;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] data0, data1;
    logic       valid0, valid1;
    logic       ready0, ready1;
    logic       tx0, tx1;
    logic       busy0, busy1;
    logic [2:0] level0, level1;

    int passed = 0;
    int total  = 0;
    int cyc    = 0;
    int rst_count = 0;

    logic [7:0] exp0[$];
    logic [7:0] exp1[$];
    int         starts0[$];

    uart_tx_stream #(.PARITY_EN(0)) u_dut0 (
        .clk(clk), .rst(rst), .data_i(data0), .valid_i(valid0), .ready_o(ready0),
        .tx_o(tx0), .busy_o(busy0), .fifo_level_o(level0)
    );

    uart_tx_stream #(.PARITY_EN(1)) u_dut1 (
        .clk(clk), .rst(rst), .data_i(data1), .valid_i(valid1), .ready_o(ready1),
        .tx_o(tx1), .busy_o(busy1), .fifo_level_o(level1)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge rst) rst_count++;

    function automatic logic line_of(input int idx);
        return (idx == 0) ? tx0 : tx1;
    endfunction

    function automatic logic busy_of(input int idx);
        return (idx == 0) ? busy0 : busy1;
    endfunction

    // Line value expected in bit slot k of a frame: start, 8 data LSB first, [parity], stop.
    function automatic logic frame_bit(input logic [7:0] b, input int par, input int k);
        logic [7:0] v;
        v = b;
        if (k == 0) return 1'b0;
        if (k <= 8) return v[k-1];
        if (k == 9 && par != 0) return 1'(($countones(v) % 2));
        return 1'b1;
    endfunction

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        total++;
        if (actual === expected) begin
            passed++;
        end else begin
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    task automatic applyStimulus(input int idx, input logic [7:0] b, input logic v);
        if (idx == 0) begin
            data0  = b;
            valid0 = v;
        end else begin
            data1  = b;
            valid1 = v;
        end
    endtask

    // Receiver: finds a start bit, samples every slot at mid-bit and scores the frame.
    task automatic monitor_line(input int idx);
        int         start_cyc;
        int         rc;
        logic       s0, pbit, sbit;
        logic [7:0] got;
        logic [7:0] want;
        forever begin
            tick();
            if (line_of(idx) === 1'b0) begin
                start_cyc = cyc;
                rc        = rst_count;
                tick(DIV / 2);
                s0 = line_of(idx);
                for (int i = 0; i < 8; i++) begin
                    tick(DIV);
                    got[i] = line_of(idx);
                end
                pbit = 1'b0;
                if (idx == 1) begin
                    tick(DIV);
                    pbit = line_of(idx);
                end
                tick(DIV);
                sbit = line_of(idx);
                if (rc == rst_count) begin
                    if (idx == 0) starts0.push_back(start_cyc);
                    checkOutput($sformatf("frame_expected%0d", idx),
                                (idx == 0) ? (exp0.size() > 0) : (exp1.size() > 0), 1);
                    if ((idx == 0 && exp0.size() > 0) || (idx == 1 && exp1.size() > 0)) begin
                        want = (idx == 0) ? exp0.pop_front() : exp1.pop_front();
                        checkOutput($sformatf("rx_start%0d", idx), s0, 0);
                        checkOutput($sformatf("rx_data%0d", idx), got, want);
                        if (idx == 1) checkOutput("rx_parity1", pbit, $countones(want) % 2);
                        checkOutput($sformatf("rx_stop%0d", idx), sbit, 1);
                    end
                end
            end
        end
    endtask

    initial monitor_line(0);
    initial monitor_line(1);

    // Push one byte into an idle instance and trace its frame slot by slot.
    task automatic send_and_trace(input int idx, input logic [7:0] b);
        int nbits;
        nbits = (idx == 1) ? 11 : 10;
        applyStimulus(idx, b, 1'b1);
        tick();
        if (idx == 0) exp0.push_back(b); else exp1.push_back(b);
        applyStimulus(idx, 8'h00, 1'b0);
        checkOutput("pre_start", line_of(idx), 1);
        tick();
        checkOutput("start_edge", line_of(idx), 0);
        tick(DIV / 2);
        for (int k = 0; k < nbits; k++) begin
            checkOutput($sformatf("slot%0d_byte%02h", k, b), line_of(idx), frame_bit(b, idx, k));
            if (k < nbits - 1) tick(DIV);
        end
        tick(DIV / 2 - 1);
        checkOutput("busy_last_cycle", busy_of(idx), 1);
        tick();
        checkOutput("busy_fall", busy_of(idx), 0);
        checkOutput("idle_line", line_of(idx), 1);
    endtask

    initial begin
        logic [7:0] b;
        int         n;
        int         bad;

        applyStimulus(0, 8'h00, 1'b0);
        applyStimulus(1, 8'h00, 1'b0);

        for (int i = 0; i < 5; i++) begin
            tick();
            checkOutput("rst_tx", tx0, 1);
            checkOutput("rst_busy", busy0, 0);
            checkOutput("rst_ready", ready0, 1);
            checkOutput("rst_level", level0, 0);
        end
        checkOutput("rst_tx1", tx1, 1);
        checkOutput("rst_level1", level1, 0);
        #2 rst = 1'b0;
        tick(2);

        send_and_trace(0, 8'hA5);
        send_and_trace(1, 8'h07);
        send_and_trace(1, 8'h03);
        tick(5);

        // Burst with valid held: accepts land on edges 0..4 and 322; other data is noise.
        starts0.delete();
        for (int c = 0; c <= 322; c++) begin
            if (c < 5) b = 8'h10 + 8'(c);
            else if (c == 322) b = 8'h15;
            else b = 8'($urandom);
            applyStimulus(0, b, 1'b1);
            tick();
            if (c < 5 || c == 322) exp0.push_back(b);
            if (c == 3)   begin checkOutput("burst_ready3", ready0, 1); checkOutput("burst_level3", level0, 3); end
            if (c == 4)   begin checkOutput("burst_ready4", ready0, 0); checkOutput("burst_level4", level0, 4); end
            if (c == 320) begin checkOutput("burst_ready320", ready0, 0); checkOutput("burst_level320", level0, 4); end
            if (c == 321) begin checkOutput("burst_ready321", ready0, 1); checkOutput("burst_level321", level0, 3); end
        end
        applyStimulus(0, 8'h00, 1'b0);
        tick(1920 - 322);
        checkOutput("burst_busy_end", busy0, 1);
        tick();
        checkOutput("burst_busy_fall", busy0, 0);
        checkOutput("burst_frames", starts0.size(), 6);
        for (int i = 1; i < starts0.size(); i++) begin
            checkOutput($sformatf("burst_gap%0d", i), starts0[i] - starts0[i-1], 10 * DIV);
        end

        for (int r = 0; r < 4; r++) begin
            n = 1 + $urandom_range(0, 2);
            for (int i = 0; i < n; i++) begin
                b = 8'($urandom);
                applyStimulus(1, b, 1'b1);
                tick();
                exp1.push_back(b);
            end
            applyStimulus(1, 8'h00, 1'b0);
            tick(n * 11 * DIV + $urandom_range(5, 40));
        end

        // Reset in the middle of a frame with two bytes still queued.
        applyStimulus(0, 8'h3C, 1'b1);
        tick();
        applyStimulus(0, 8'($urandom), 1'b1);
        tick();
        applyStimulus(0, 8'($urandom), 1'b1);
        tick();
        applyStimulus(0, 8'h00, 1'b0);
        tick(79);
        checkOutput("mid_bit1", tx0, frame_bit(8'h3C, 0, 2));
        tick(60);
        checkOutput("mid_level", level0, 2);
        checkOutput("mid_bit3", tx0, frame_bit(8'h3C, 0, 4));
        #2 rst = 1'b1;
        #1;
        checkOutput("async_tx", tx0, 1);
        checkOutput("async_level", level0, 0);
        checkOutput("async_busy", busy0, 0);
        checkOutput("async_ready", ready0, 1);
        tick(3);
        #2 rst = 1'b0;
        bad = 0;
        for (int i = 0; i < 1000; i++) begin
            tick();
            if (tx0 !== 1'b1 || busy0 !== 1'b0) bad++;
        end
        checkOutput("quiet_after_reset", bad, 0);

        tick(50);
        checkOutput("exp0_drained", exp0.size(), 0);
        checkOutput("exp1_drained", exp1.size(), 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
